pipe_stages: RTL and testbench

- Parametrised successor to the single-register DFF: a chain of DEPTH registered stages, each WIDTH bits wide, with a valid bit per stage.
- Valid/ready handshake on both ends, bubble collapsing, synchronous flush and an occupancy count.
- Used as the team's generic retiming/pipeline-delay element between producer and consumer blocks that may stall.

---
 rtl/pipe_stages_pkg.sv | 9 +
 rtl/pipe_stage.sv | 29 ++
 rtl/pipe_stages.sv | 87 ++++++++
 tb/tb_pipe_stages.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stages_pkg.sv
// Shared helpers for the pipe_stages retiming chain.
package pipe_stages_pkg;

  // Width of an occupancy counter that must hold 0..depth, never narrower than 1 bit.
  function automatic int unsigned count_width(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One register stage of pipe_stages: WIDTH-bit data plus a valid bit.
module pipe_stage #(
  parameter int unsigned      WIDTH      = 4,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             advance,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Flush only drops the valid bit; the data register keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= RESET_DATA;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (advance) begin
      valid <= in_valid;
      data  <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stages.sv
// DEPTH-stage valid/ready pipeline with bubble collapsing, flush and occupancy count.
module pipe_stages
  import pipe_stages_pkg::*;
#(
  parameter int unsigned      WIDTH      = 4,
  parameter int unsigned      DEPTH      = 3,
  parameter logic [WIDTH-1:0] RESET_DATA = '0,
  localparam int unsigned     CW         = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] stg_in_valid;
  logic [WIDTH-1:0] stg_in_data [DEPTH];
  logic             in_xfer;
  logic             out_xfer;

  // A stage can move when the consumer takes the head or any stage at or after it is empty;
  // this is the unrolled form of the downstream ready chain.
  always_comb begin
    adv = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      adv[i] = out_ready;
      for (int j = i; j < int'(DEPTH); j++) begin
        if (!valid[j]) adv[i] = 1'b1;
      end
    end
  end

  assign in_ready  = !rst && !flush && adv[0];
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];
  assign out_xfer  = out_valid && out_ready;

  // Stage 0 takes the producer; every later stage takes its predecessor.
  always_comb begin
    stg_in_valid = '0;
    for (int i = 0; i < int'(DEPTH); i++) stg_in_data[i] = '0;
    stg_in_valid[0] = in_xfer;
    stg_in_data[0]  = in_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      stg_in_valid[i] = valid[i-1];
      stg_in_data[i]  = data[i-1];
    end
  end

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_stage
    pipe_stage #(
      .WIDTH      (WIDTH),
      .RESET_DATA (RESET_DATA)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .advance  (adv[g]),
      .in_valid (stg_in_valid[g]),
      .in_data  (stg_in_data[g]),
      .valid    (valid[g]),
      .data     (data[g])
    );
  end

  // Occupancy tracks transfers; a simultaneous in and out leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else if (in_xfer && !out_xfer) begin
      count <= count + CW'(1);
    end else if (out_xfer && !in_xfer) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stages.sv
// Directed bench for pipe_stages (WIDTH=4, DEPTH=3) with per-cycle occupancy tracking.
module tb_pipe_stages;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 3;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  int n_assert = 0;
  int n_fail   = 0;
  int mcount   = 0;

  pipe_stages #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .RESET_DATA ('0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the bench predicts occupancy from the handshakes seen before the edge.
  task automatic step();
    if (rst || flush) mcount = 0;
    else begin
      if (in_valid && in_ready) mcount++;
      if (out_valid && out_ready) mcount--;
    end
    @(posedge clk);
    #1;
    chk("count_track", 32'(count), mcount);
    chk("count_max", 32'(count <= 2'(DEPTH)), 1);
  endtask

  task automatic drive(input logic iv, input logic [3:0] id, input logic ordy);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    step();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    step();
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 1);
    chk("idle_out_valid", 32'(out_valid), 0);
    chk("idle_out_data", 32'(out_data), 0);
    chk("idle_count", 32'(count), 0);

    // Single item: accepted in cycle 0, visible only in cycle 3
    drive(1'b1, 4'hA, 1'b1);
    chk("single_in_ready", 32'(in_ready), 1);
    step();
    drive(1'b0, 4'h0, 1'b1);
    chk("single_c1_ov", 32'(out_valid), 0);
    chk("single_c1_cnt", 32'(count), 1);
    step();
    chk("single_c2_ov", 32'(out_valid), 0);
    chk("single_c2_cnt", 32'(count), 1);
    step();
    chk("single_c3_ov", 32'(out_valid), 1);
    chk("single_c3_od", 32'(out_data), 'hA);
    chk("single_c3_cnt", 32'(count), 1);
    step();
    chk("single_c4_ov", 32'(out_valid), 0);
    chk("single_c4_cnt", 32'(count), 0);

    // Streaming 1..8 with the consumer always ready
    for (int j = 0; j < 11; j++) begin
      if (j < 8) drive(1'b1, 4'(j + 1), 1'b1);
      else       drive(1'b0, 4'h0, 1'b1);
      if (j < 8) chk($sformatf("stream_ir%0d", j), 32'(in_ready), 1);
      if (j >= 3) begin
        chk($sformatf("stream_ov%0d", j), 32'(out_valid), 1);
        chk($sformatf("stream_od%0d", j), 32'(out_data), 32'(j - 2));
      end else begin
        chk($sformatf("stream_ov%0d", j), 32'(out_valid), 0);
      end
      step();
    end
    chk("stream_end_ov", 32'(out_valid), 0);
    chk("stream_end_cnt", 32'(count), 0);

    // Backpressure until full
    drive(1'b1, 4'h3, 1'b0); step();
    drive(1'b1, 4'h5, 1'b0); step();
    drive(1'b1, 4'h7, 1'b0); step();
    drive(1'b1, 4'h9, 1'b0);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_cnt", 32'(count), 3);
    chk("full_ov", 32'(out_valid), 1);
    chk("full_od", 32'(out_data), 'h3);
    step();
    chk("full_hold_od", 32'(out_data), 'h3);
    chk("full_hold_cnt", 32'(count), 3);
    drive(1'b1, 4'h9, 1'b1);
    chk("full_pass_in_ready", 32'(in_ready), 1);
    chk("full_pass_od", 32'(out_data), 'h3);
    step();
    drive(1'b0, 4'h0, 1'b0);
    chk("full_after_cnt", 32'(count), 3);
    chk("full_after_od", 32'(out_data), 'h5);
    drive(1'b0, 4'h0, 1'b1);
    step();
    chk("drain_od7", 32'(out_data), 'h7);
    step();
    chk("drain_od9", 32'(out_data), 'h9);
    chk("drain_ov9", 32'(out_valid), 1);
    step();
    chk("drain_cnt", 32'(count), 0);

    // Bubble collapse while the output is stalled
    drive(1'b1, 4'hC, 1'b0); step();
    drive(1'b0, 4'h0, 1'b0); step();
    step();
    drive(1'b1, 4'hD, 1'b0); step();
    drive(1'b0, 4'h0, 1'b0);
    chk("bub_c4_cnt", 32'(count), 2);
    chk("bub_c4_od", 32'(out_data), 'hC);
    step();
    chk("bub_c5_cnt", 32'(count), 2);
    chk("bub_c5_od", 32'(out_data), 'hC);
    drive(1'b0, 4'h0, 1'b1);
    chk("bub_c5_ov", 32'(out_valid), 1);
    step();
    chk("bub_c6_ov", 32'(out_valid), 1);
    chk("bub_c6_od", 32'(out_data), 'hD);
    step();
    chk("bub_c7_cnt", 32'(count), 0);

    // Flush with a concurrent output transfer and a refused input
    drive(1'b1, 4'h6, 1'b0); step();
    drive(1'b1, 4'h7, 1'b0); step();
    drive(1'b0, 4'h0, 1'b0); step();
    chk("fl_pre_cnt", 32'(count), 2);
    chk("fl_pre_ov", 32'(out_valid), 1);
    chk("fl_pre_od", 32'(out_data), 'h6);
    flush = 1'b1;
    drive(1'b1, 4'hE, 1'b1);
    chk("fl_in_ready", 32'(in_ready), 0);
    chk("fl_xfer_od", 32'(out_data), 'h6);
    step();
    flush = 1'b0;
    drive(1'b0, 4'h0, 1'b1);
    chk("fl_post_cnt", 32'(count), 0);
    chk("fl_post_ov", 32'(out_valid), 0);
    chk("fl_post_od_kept", 32'(out_data), 'h6);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("fl_no_e_ov%0d", k), 32'(out_valid), 0);
    end

    // Reset and flush together
    drive(1'b1, 4'h2, 1'b0); step();
    drive(1'b1, 4'h4, 1'b0); step();
    drive(1'b0, 4'h0, 1'b0); step();
    chk("rf_pre_cnt", 32'(count), 2);
    chk("rf_pre_od", 32'(out_data), 'h2);
    rst = 1'b1; flush = 1'b1;
    drive(1'b1, 4'hE, 1'b1);
    chk("rf_in_ready", 32'(in_ready), 0);
    step();
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, 4'h0, 1'b0);
    chk("rf_post_cnt", 32'(count), 0);
    chk("rf_post_ov", 32'(out_valid), 0);
    chk("rf_post_od", 32'(out_data), 0);
    chk("rf_post_in_ready", 32'(in_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
